// File: rtl/security_portal_ctrl.sv
// Portal sequencing controller: sensor-driven passage FSM with occupancy count,
// metal-detector lockout with a timed buzzer, and Moore-decoded lamps.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for a sensor
// CHECK    | one-cycle metal-detector sample for an entry attempt
// ENTER    | entry passage in progress, timed
// EXIT     | exit passage in progress, timed
// CONFLICT | both sensors active, waiting for one side to clear
// LOCK     | metal detected; held until guard override with entrance clear
// DENY     | portal full; held until both sensors clear
module security_portal_ctrl #(
  parameter int CAP      = 15,
  parameter int CNT_W    = 4,
  parameter int TMO      = 8,
  parameter int BUZZ_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_out,
  input  logic             metal,
  input  logic             ovr,
  output logic             green,
  output logic             red,
  output logic             buzz,
  output logic [1:0]       dir,
  output logic [CNT_W-1:0] occ,
  output logic             full,
  output logic [2:0]       state_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] ENTER    = 3'd2;
  localparam logic [2:0] EXIT     = 3'd3;
  localparam logic [2:0] CONFLICT = 3'd4;
  localparam logic [2:0] LOCK     = 3'd5;
  localparam logic [2:0] DENY     = 3'd6;

  localparam int TW = $clog2(TMO);
  localparam int BW = $clog2(BUZZ_CYC + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TMO - 1);
  localparam logic [BW-1:0]    BUZZ_N   = BW'(BUZZ_CYC);
  localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAP);

  logic [2:0]       state, nxt;
  logic [CNT_W-1:0] occ_nxt;
  logic [TW-1:0]    timer;
  logic [BW-1:0]    bcnt;

  assign full = (occ == CAP_V);

  always_comb begin
    nxt     = state;
    occ_nxt = occ;
    case (state)
      IDLE: begin
        if (s_in && !s_out)      nxt = full ? DENY : CHECK;
        else if (!s_in && s_out) nxt = EXIT;
        else if (s_in && s_out)  nxt = CONFLICT;
      end
      CHECK: nxt = metal ? LOCK : ENTER;
      ENTER, EXIT: begin
        // a clear on the timeout cycle still counts as a completed passage
        if (!s_in && !s_out) begin
          nxt = IDLE;
          if (state == ENTER) begin
            if (occ != CAP_V) occ_nxt = occ + CNT_W'(1);
          end else if (occ != '0) begin
            occ_nxt = occ - CNT_W'(1);
          end
        end else if (timer == TMO_LAST) begin
          nxt = IDLE;
        end
      end
      CONFLICT: begin
        if (!s_in && s_out)       nxt = EXIT;
        else if (!s_in && !s_out) nxt = IDLE;
      end
      LOCK: if (ovr && !s_in) nxt = IDLE;
      DENY: if (!s_in && !s_out) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      occ   <= '0;
      timer <= '0;
      bcnt  <= '0;
    end else begin
      state <= nxt;
      occ   <= occ_nxt;
      if (nxt != state)
        timer <= '0;
      else if (state == ENTER || state == EXIT)
        timer <= timer + TW'(1);
      // buzzer count restarts on every fresh entry into LOCK and parks at BUZZ_N
      if (nxt == LOCK && state != LOCK)
        bcnt <= '0;
      else if (state == LOCK && bcnt != BUZZ_N)
        bcnt <= bcnt + BW'(1);
    end
  end

  assign state_o = state;
  assign green   = (state == ENTER) || (state == EXIT);
  assign red     = (state == CONFLICT) || (state == LOCK) || (state == DENY);
  assign dir     = (state == CHECK || state == ENTER) ? 2'b01 :
                   (state == EXIT) ? 2'b10 : 2'b00;
  assign buzz    = (state == LOCK) && (bcnt != BUZZ_N);

endmodule

// File: tb/tb_security_portal_ctrl.sv
// Bench for security_portal_ctrl: per-scenario step tables, expected outputs
// queued as each step is driven and popped/compared after the clock edge.
module tb_security_portal_ctrl;

  logic       clk = 1'b0;
  logic       reset, s_in, s_out, metal, ovr;
  logic       green, red, buzz, full;
  logic [1:0] dir;
  logic [3:0] occ;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       rst, si, so, m, o;
    logic [2:0] st;
    logic [3:0] occ;
    logic       bz;
  } step_t;

  logic [12:0] exp_q[$];
  step_t       steps[$];

  security_portal_ctrl dut (
    .clk(clk), .reset(reset), .s_in(s_in), .s_out(s_out), .metal(metal),
    .ovr(ovr), .green(green), .red(red), .buzz(buzz), .dir(dir), .occ(occ),
    .full(full), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic rst, si, so, m, o,
                               input logic [2:0] st, input logic [3:0] oc,
                               input logic bz);
    step_t s;
    s.rst = rst; s.si = si; s.so = so; s.m = m; s.o = o;
    s.st = st; s.occ = oc; s.bz = bz;
    return s;
  endfunction

  // expected output vector {state, occ, green, red, buzz, dir, full}
  function automatic logic [12:0] expect_of(input step_t s);
    logic g, r, f;
    logic [1:0] d;
    g = (s.st == 3'd2) || (s.st == 3'd3);
    r = (s.st == 3'd4) || (s.st == 3'd5) || (s.st == 3'd6);
    d = (s.st == 3'd1 || s.st == 3'd2) ? 2'b01 : (s.st == 3'd3) ? 2'b10 : 2'b00;
    f = (s.occ == 4'd15);
    return {s.st, s.occ, g, r, s.bz, d, f};
  endfunction

  task automatic drive(input step_t s);
    reset = s.rst; s_in = s.si; s_out = s.so; metal = s.m; ovr = s.o;
    exp_q.push_back(expect_of(s));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] observed();
    return {state_o, occ, green, red, buzz, dir, full};
  endfunction

  task automatic test_reset();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(1, 1, 1, 1, 1, 3'd0, 4'd0, 0));
    steps.push_back(mk(1, 1, 0, 0, 0, 3'd0, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL reset step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_entry();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd2, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd1, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL entry step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_exit();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd3, 4'd1, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd0, 0));
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd3, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL exit step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_conflict();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(0, 1, 1, 0, 0, 3'd4, 4'd0, 0));
    steps.push_back(mk(0, 1, 1, 0, 0, 3'd4, 4'd0, 0));
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd4, 4'd0, 0));
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd3, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd0, 0));
    steps.push_back(mk(0, 1, 1, 0, 0, 3'd4, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL conflict step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_lock();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 0));  // override ignored in IDLE
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'd0, 0));
    steps.push_back(mk(0, 1, 0, 1, 0, 3'd5, 4'd0, 1));
    steps.push_back(mk(0, 1, 0, 0, 1, 3'd5, 4'd0, 1));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd5, 4'd0, 1));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd5, 4'd0, 1));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd5, 4'd0, 0));
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd5, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 0));
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 1, 0, 3'd5, 4'd0, 1));  // buzzer restarts
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd5, 4'd0, 1));
    steps.push_back(mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL lock step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_timeout();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'd0, 0));
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd2, 4'd0, 0));
    for (int k = 0; k < 7; k++) steps.push_back(mk(0, 1, 0, 0, 0, 3'd2, 4'd0, 0));
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd0, 4'd0, 0));  // 8th cycle in ENTER aborts
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd0, 0));
    // clear exactly on the timeout cycle counts the passage
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'd0, 0));
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd2, 4'd0, 0));
    for (int k = 0; k < 7; k++) steps.push_back(mk(0, 0, 1, 0, 0, 3'd2, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd1, 0));
    // exit timeout leaves count unchanged
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd3, 4'd1, 0));
    for (int k = 0; k < 7; k++) steps.push_back(mk(0, 0, 1, 0, 0, 3'd3, 4'd1, 0));
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd0, 4'd1, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL timeout step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_capacity();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(1, 0, 0, 0, 0, 3'd0, 4'd0, 0));
    for (int k = 0; k < 15; k++) begin
      steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'(k), 0));
      steps.push_back(mk(0, 1, 0, 0, 0, 3'd2, 4'(k), 0));
      steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'(k + 1), 0));
    end
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd6, 4'd15, 0));
    steps.push_back(mk(0, 1, 0, 0, 1, 3'd6, 4'd15, 0));
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd6, 4'd15, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd15, 0));
    steps.push_back(mk(0, 0, 1, 0, 0, 3'd3, 4'd15, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'd14, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL capacity step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e, g;
    steps.delete();
    steps.push_back(mk(1, 0, 0, 0, 0, 3'd0, 4'd0, 0));
    for (int k = 0; k < 5; k++) begin
      steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'(k), 0));
      steps.push_back(mk(0, 0, 0, 0, 0, 3'd2, 4'(k), 0));
      steps.push_back(mk(0, 0, 0, 0, 0, 3'd0, 4'(k + 1), 0));
    end
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'd5, 0));
    steps.push_back(mk(0, 1, 0, 1, 0, 3'd5, 4'd5, 1));
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd5, 4'd5, 1));
    steps.push_back(mk(1, 1, 0, 1, 0, 3'd0, 4'd0, 0));
    steps.push_back(mk(0, 1, 0, 0, 0, 3'd1, 4'd0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 3'd2, 4'd0, 0));
    steps.push_back(mk(1, 0, 0, 0, 0, 3'd0, 4'd0, 0));  // reset beats passage clear
    foreach (steps[i]) begin
      drive(steps[i]);
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL reset_mid step %0d: got=%h exp=%h", i, g, e); end
    end
  endtask

  initial begin
    reset = 1'b1; s_in = 1'b0; s_out = 1'b0; metal = 1'b0; ovr = 1'b0;
    test_reset();
    test_entry();
    test_exit();
    test_conflict();
    test_lock();
    test_timeout();
    test_capacity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/security_portal_ctrl.md
SECURITY_PORTAL_CTRL -- requirements
Module: security_portal_ctrl

Interface
REQ-001 Parameter CAP, default 15: maximum occupancy; 1 <= CAP <= 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 4: width of the occupancy counter.
REQ-003 Parameter TMO, default 8: passage timeout in cycles; TMO >= 2.
REQ-004 Parameter BUZZ_CYC, default 4: buzzer pulse length in cycles; BUZZ_CYC >= 1.
REQ-005 CLOCK  in  1  single clock; all state changes on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 S_IN  in  1  entrance-side presence sensor.
REQ-008 S_OUT  in  1  exit-side presence sensor.
REQ-009 METAL  in  1  metal detector.
REQ-010 OVR  in  1  guard override (unlock).
REQ-011 GREEN  out  1  pass permitted lamp.
REQ-012 RED  out  1  stop lamp.
REQ-013 BUZZ  out  1  audible alarm.
REQ-014 DIR  out  2  rotation: 01 entering, 10 exiting, 00 none.
REQ-015 OCC  out  CNT_W  current occupancy.
REQ-016 FULL  out  1  high when OCC == CAP.
REQ-017 STATE_O  out  3  state code for the debug display.

Function
REQ-018 States and codes SHALL be: IDLE=0, CHECK=1, ENTER=2, EXIT=3, CONFLICT=4, LOCK=5, DENY=6; code 7 SHALL return to IDLE on the next edge.
REQ-019 IDLE transitions SHALL be:
- S_IN & !S_OUT: to DENY if FULL, else to CHECK.
- !S_IN & S_OUT: to EXIT.
- S_IN & S_OUT: to CONFLICT.
- otherwise: stay in IDLE.
REQ-020 CHECK SHALL last exactly one cycle; METAL=1 sampled in CHECK SHALL go to LOCK, else to ENTER.
REQ-021 ENTER and EXIT SHALL run a passage timer: cleared on state entry, incremented every cycle in the state.
REQ-022 In ENTER/EXIT, S_IN=0 & S_OUT=0 SHALL go to IDLE and update OCC on the same edge:
- ENTER: OCC+1, saturating at CAP.
- EXIT: OCC-1, saturating at 0.
REQ-023 In ENTER/EXIT, timer == TMO-1 with sensors not both clear SHALL go to IDLE with OCC unchanged (aborted passage).
REQ-024 If sensors clear on the timeout cycle, the clear rule SHALL win and OCC SHALL update.
REQ-025 CONFLICT transitions SHALL be:
- !S_IN & S_OUT: to EXIT (exit has priority).
- both clear: to IDLE.
- otherwise: stay.
REQ-026 LOCK SHALL hold until OVR=1 & S_IN=0, then go to IDLE with OCC unchanged; OVR SHALL be ignored in all other states.
REQ-027 DENY SHALL hold until both sensors clear, then go to IDLE.
REQ-028 Outputs SHALL be decoded from the registered state (Moore, no input-to-output paths):
- GREEN = ENTER | EXIT.
- RED = CONFLICT | LOCK | DENY.
- DIR = 01 in CHECK/ENTER, 10 in EXIT, else 00.
REQ-029 BUZZ SHALL be high for exactly the first BUZZ_CYC cycles in LOCK, counted from the first cycle STATE_O=5, then low while LOCK persists.
REQ-030 The buzzer counter SHALL restart on every new entry into LOCK.
REQ-031 FULL SHALL be combinational from OCC.
REQ-032 STATE_O SHALL equal the current state code.

Reset
REQ-033 RESET=1 at a rising edge SHALL force state IDLE, OCC=0, timer=0 and buzzer counter=0, overriding all other inputs including mid-passage and mid-LOCK.
REQ-034 After reset, outputs SHALL be GREEN=0, RED=0, BUZZ=0, DIR=00, FULL=0, STATE_O=0.
REQ-035 Operation SHALL resume on the first edge with RESET=0.

Verification
REQ-036 Normal entry: S_IN=1 one cycle, METAL=0, then sensors 0 -> states 0,1,2,0; GREEN high in ENTER; OCC 0->1.
REQ-037 Metal lock: S_IN=1, METAL=1 in CHECK -> LOCK; RED=1; BUZZ high exactly 4 cycles; OVR=1 with S_IN=0 -> IDLE; OCC unchanged.
REQ-038 Capacity: 15 entries -> FULL=1; 16th S_IN -> DENY, RED=1, OCC stays 15; exit passage -> OCC=14, FULL=0.
REQ-039 Timeout: enter ENTER, hold S_IN=1 -> IDLE after 8 cycles in ENTER; OCC unchanged; exit at OCC=0 keeps OCC=0.
REQ-040 Conflict: S_IN=S_OUT=1 -> CONFLICT, RED=1; drop S_IN -> EXIT, DIR=10.
REQ-041 Reset mid-operation: assert RESET during LOCK with OCC=5 -> next edge IDLE, OCC=0, BUZZ=0.
